alu_issue_stage: RTL



---
 rtl/alu_issue_stage_if.sv | 32 +++
 rtl/alu_issue_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage_if.sv
// ID->EX issue bus: ID-side beat inputs, EX-side handshake and registered payload.
interface alu_issue_stage_if #(
    parameter int DW = 32
);
    logic          i_id_valid;
    logic          o_id_ready;
    logic [DW-1:0] i_instr;
    logic [DW-1:0] i_pc;
    logic [DW-1:0] i_rs1_data;
    logic [DW-1:0] i_rs2_data;
    logic          i_flush;
    logic          i_ex_ready;
    logic          o_ex_valid;
    logic [DW-1:0] o_op_a;
    logic [DW-1:0] o_op_b;
    logic [3:0]    o_alu_op;
    logic [4:0]    o_rd_addr;
    logic          o_rd_wren;
    logic          o_illegal;

    // Issue stage side
    modport slave (
        input  i_id_valid, i_instr, i_pc, i_rs1_data, i_rs2_data, i_flush, i_ex_ready,
        output o_id_ready, o_ex_valid, o_op_a, o_op_b, o_alu_op, o_rd_addr, o_rd_wren, o_illegal
    );

    // Driver / observer side
    modport master (
        output i_id_valid, i_instr, i_pc, i_rs1_data, i_rs2_data, i_flush, i_ex_ready,
        input  o_id_ready, o_ex_valid, o_op_a, o_op_b, o_alu_op, o_rd_addr, o_rd_wren, o_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I ID->EX issue stage: decodes ALU op/operands and holds them in a
// single-entry pipeline register with valid/ready, stall and flush.
module alu_issue_stage #(
    parameter int DW = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    alu_issue_stage_if.slave   bus
);
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0100,
        ALU_SLTU = 4'b0110,
        ALU_XOR  = 4'b1000,
        ALU_SRL  = 4'b1010,
        ALU_SRA  = 4'b1011,
        ALU_OR   = 4'b1100,
        ALU_AND  = 4'b1110
    } alu_op_e;

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_BRANCH = 7'b1100011,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111
    } opcode_e;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // f3 -> ALU op; alt selects SUB/SRA on the 000/101 slots
    function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  f3_to_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  f3_to_op = ALU_SLL;
            3'b010:  f3_to_op = ALU_SLT;
            3'b011:  f3_to_op = ALU_SLTU;
            3'b100:  f3_to_op = ALU_XOR;
            3'b101:  f3_to_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  f3_to_op = ALU_OR;
            default: f3_to_op = ALU_AND;
        endcase
    endfunction

    logic [6:0]    opcode;
    logic [2:0]    f3;
    logic [6:0]    f7;
    logic [4:0]    rd;
    logic [DW-1:0] imm_i, imm_s, imm_u, shamt;

    logic [DW-1:0] dec_a, dec_b;
    alu_op_e       dec_op;
    logic          dec_wb, dec_wren, dec_illegal;

    logic          ex_valid_q, ex_valid_d;
    logic [DW-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    alu_op_e       alu_op_q, alu_op_d;
    logic [4:0]    rd_addr_q, rd_addr_d;
    logic          rd_wren_q, rd_wren_d;
    logic          illegal_q, illegal_d;
    logic          id_ready, load;

    // Instruction field extraction and immediates
    always_comb begin
        opcode = bus.i_instr[6:0];
        f3     = bus.i_instr[14:12];
        f7     = bus.i_instr[31:25];
        rd     = bus.i_instr[11:7];
        imm_i  = {{20{bus.i_instr[31]}}, bus.i_instr[31:20]};
        imm_s  = {{20{bus.i_instr[31]}}, bus.i_instr[31:25], bus.i_instr[11:7]};
        imm_u  = {bus.i_instr[31:12], 12'b0};
        shamt  = {27'b0, bus.i_instr[24:20]};
    end

    // Decode operands, ALU op and writeback; illegal beats are forced to a zero payload
    always_comb begin
        dec_a       = '0;
        dec_b       = '0;
        dec_op      = ALU_ADD;
        dec_wb      = 1'b0;
        dec_illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_a  = bus.i_rs1_data;
                dec_b  = bus.i_rs2_data;
                dec_op = f3_to_op(f3, f7[5]);
                dec_wb = 1'b1;
                if (!((f7 == F7_ZERO) || ((f7 == F7_ALT) && (f3 == 3'b000 || f3 == 3'b101))))
                    dec_illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                dec_a  = bus.i_rs1_data;
                dec_b  = imm_i;
                dec_wb = 1'b1;
                if (f3 == 3'b001) begin
                    dec_b  = shamt;
                    dec_op = ALU_SLL;
                    if (f7 != F7_ZERO) dec_illegal = 1'b1;
                end else if (f3 == 3'b101) begin
                    dec_b = shamt;
                    if (f7 == F7_ZERO)     dec_op = ALU_SRL;
                    else if (f7 == F7_ALT) dec_op = ALU_SRA;
                    else                   dec_illegal = 1'b1;
                end else begin
                    dec_op = f3_to_op(f3, 1'b0);
                end
            end
            OPC_LUI: begin
                dec_b  = imm_u;
                dec_wb = 1'b1;
            end
            OPC_AUIPC: begin
                dec_a  = bus.i_pc;
                dec_b  = imm_u;
                dec_wb = 1'b1;
            end
            OPC_LOAD: begin
                dec_a  = bus.i_rs1_data;
                dec_b  = imm_i;
                dec_wb = 1'b1;
            end
            OPC_STORE: begin
                dec_a = bus.i_rs1_data;
                dec_b = imm_s;
            end
            OPC_BRANCH: begin
                dec_a  = bus.i_rs1_data;
                dec_b  = bus.i_rs2_data;
                dec_op = ALU_SUB;
            end
            OPC_JAL, OPC_JALR: begin
                dec_a  = bus.i_pc;
                dec_b  = 32'd4;
                dec_wb = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            dec_a  = '0;
            dec_b  = '0;
            dec_op = ALU_ADD;
            dec_wb = 1'b0;
        end
        dec_wren = dec_wb && (rd != 5'd0);
    end

    // Pipeline register next state: flush beats load, load beats consume, stall holds
    always_comb begin
        id_ready   = !ex_valid_q || bus.i_ex_ready;
        load       = bus.i_id_valid && id_ready && !bus.i_flush;
        ex_valid_d = ex_valid_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        alu_op_d   = alu_op_q;
        rd_addr_d  = rd_addr_q;
        rd_wren_d  = rd_wren_q;
        illegal_d  = illegal_q;
        if (bus.i_flush) begin
            ex_valid_d = 1'b0;
        end else if (load) begin
            ex_valid_d = 1'b1;
            op_a_d     = dec_a;
            op_b_d     = dec_b;
            alu_op_d   = dec_op;
            rd_addr_d  = rd;
            rd_wren_d  = dec_wren;
            illegal_d  = dec_illegal;
        end else if (bus.i_ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    // ID/EX register with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ex_valid_q <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            alu_op_q   <= ALU_ADD;
            rd_addr_q  <= '0;
            rd_wren_q  <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            alu_op_q   <= alu_op_d;
            rd_addr_q  <= rd_addr_d;
            rd_wren_q  <= rd_wren_d;
            illegal_q  <= illegal_d;
        end
    end

    assign bus.o_id_ready = id_ready;
    assign bus.o_ex_valid = ex_valid_q;
    assign bus.o_op_a     = op_a_q;
    assign bus.o_op_b     = op_b_q;
    assign bus.o_alu_op   = alu_op_q;
    assign bus.o_rd_addr  = rd_addr_q;
    assign bus.o_rd_wren  = rd_wren_q;
    assign bus.o_illegal  = illegal_q;
endmodule
